// File: rtl/key_word_gen.sv
// key_word_gen: AES key-expansion word datapath (AES-128/192/256).
// Drives the external index counter's enable, takes the index and phase
// flags back from it, computes w[i] and streams each word downstream over a
// valid/ready handshake. SubWord uses an external combinational 4-byte S-box.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   start_in              latch key_in/conf_in and begin (only honoured in IDLE)
//   conf_in[1:0]          00 Nk4, 01 Nk6, 10/11 Nk8
//   key_in[255:0]         cipher key, word 0 in [255:224]
//   cnt_en_out            counter enable; one word is produced per enabled cycle
//   i_in, nw_imodk_in, mod256_4_in, fst_cpy_in, last_in   counter index and flags
//   sbox_addr_out/sbox_data_in   S-box request and combinational response
//   word_out, word_idx_out, word_valid_out, word_ready_in  word stream
//   busy_out, done_out    status; done_out pulses once after the final word
module key_word_gen #(
  parameter int WORD_W = 32,
  parameter int MAX_NK = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [1:0]        conf_in,
  input  logic [255:0]      key_in,
  output logic              cnt_en_out,
  input  logic [5:0]        i_in,
  input  logic              nw_imodk_in,
  input  logic              mod256_4_in,
  input  logic              fst_cpy_in,
  input  logic              last_in,
  output logic [WORD_W-1:0] sbox_addr_out,
  input  logic [WORD_W-1:0] sbox_data_in,
  output logic [WORD_W-1:0] word_out,
  output logic [5:0]        word_idx_out,
  output logic              word_valid_out,
  input  logic              word_ready_in,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COPY   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        conf_q, conf_d;
  logic [255:0]      key_q, key_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [WORD_W-1:0] hist_q [MAX_NK];
  logic [WORD_W-1:0] hist_d [MAX_NK];
  logic [WORD_W-1:0] word_q, word_d;
  logic [5:0]        idx_q, idx_d;
  logic              valid_q, valid_d;

  logic              step_s;
  logic              start_ok_s;
  logic [WORD_W-1:0] key_word_s;
  logic [WORD_W-1:0] prev_s;
  logic [WORD_W-1:0] old_s;
  logic [WORD_W-1:0] temp_s;
  logic [WORD_W-1:0] w_s;
  logic [WORD_W-1:0] sbox_addr_s;

  // GF(2^8) multiply by x, used to advance the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // A word is produced whenever the output register is free or being drained.
  assign step_s     = ((state_q == S_COPY) || (state_q == S_EXPAND)) &&
                      (!valid_q || word_ready_in);
  assign start_ok_s = (state_q == S_IDLE) && start_in;

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start_in ? S_COPY : S_IDLE;
      S_COPY:   state_d = (step_s && fst_cpy_in) ? S_EXPAND : S_COPY;
      S_EXPAND: state_d = (step_s && last_in) ? S_DONE : S_EXPAND;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status and counter-enable outputs decoded from the state.
  always_comb begin
    busy_out   = (state_q != S_IDLE);
    done_out   = (state_q == S_DONE);
    cnt_en_out = step_s;
  end

  // Word computation: key copy, or w[i-Nk] ^ temp during expansion.
  always_comb begin
    prev_s      = hist_q[0];
    key_word_s  = key_q[{3'd7 - i_in[2:0], 5'd0} +: WORD_W];
    sbox_addr_s = '0;
    temp_s      = '0;
    w_s         = '0;
    case (conf_q)
      2'b00:   old_s = hist_q[3];
      2'b01:   old_s = hist_q[5];
      default: old_s = hist_q[MAX_NK-1];
    endcase
    if (state_q == S_COPY) begin
      w_s = key_word_s;
    end else if (state_q == S_EXPAND) begin
      if (nw_imodk_in) begin
        // RotWord then SubWord, then the round constant into the top byte.
        sbox_addr_s = {prev_s[23:0], prev_s[31:24]};
        temp_s      = sbox_data_in ^ {rcon_q, 24'h000000};
      end else if (mod256_4_in) begin
        sbox_addr_s = prev_s;
        temp_s      = sbox_data_in;
      end else begin
        sbox_addr_s = prev_s;
        temp_s      = prev_s;
      end
      w_s = old_s ^ temp_s;
    end else begin
      w_s = '0;
    end
  end

  assign sbox_addr_out = sbox_addr_s;

  // Datapath next-state: load on start, shift history on each produced word.
  always_comb begin
    conf_d  = conf_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    hist_d  = hist_q;
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (start_ok_s) begin
      conf_d = conf_in;
      key_d  = key_in;
      rcon_d = 8'h01;
      for (int k = 0; k < MAX_NK; k++) begin
        hist_d[k] = '0;
      end
    end else if (step_s) begin
      word_d    = w_s;
      idx_d     = i_in;
      valid_d   = 1'b1;
      hist_d[0] = w_s;
      for (int k = 1; k < MAX_NK; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      if ((state_q == S_EXPAND) && nw_imodk_in) begin
        rcon_d = xtime(rcon_q);
      end else begin
        rcon_d = rcon_q;
      end
    end else if (valid_q && word_ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      conf_q  <= 2'b00;
      key_q   <= '0;
      rcon_q  <= 8'h01;
      for (int k = 0; k < MAX_NK; k++) begin
        hist_q[k] <= '0;
      end
      word_q  <= '0;
      idx_q   <= 6'd0;
      valid_q <= 1'b0;
    end else begin
      conf_q  <= conf_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      hist_q  <= hist_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign word_out       = word_q;
  assign word_idx_out   = idx_q;
  assign word_valid_out = valid_q;

endmodule

// File: tb/tb_key_word_gen.sv
// Testbench for key_word_gen: models the index counter and the S-box,
// scoreboards the word stream against an independent key-expansion model and
// spot-checks published FIPS-197 words.
module tb_key_word_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [1:0]   conf_in;
  logic [255:0] key_in;
  logic         cnt_en;
  logic [5:0]   cnt_i;
  logic         nw, mod4, fst, last;
  logic [31:0]  sbox_addr, sbox_data;
  logic [31:0]  word;
  logic [5:0]   idx;
  logic         valid, ready, busy, done;

  key_word_gen dut (
    .clk_in(clk), .rst_in(rst), .start_in(start_in), .conf_in(conf_in),
    .key_in(key_in), .cnt_en_out(cnt_en), .i_in(cnt_i),
    .nw_imodk_in(nw), .mod256_4_in(mod4), .fst_cpy_in(fst), .last_in(last),
    .sbox_addr_out(sbox_addr), .sbox_data_in(sbox_data),
    .word_out(word), .word_idx_out(idx), .word_valid_out(valid),
    .word_ready_in(ready), .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // AES S-box.
  logic [2047:0] sbox_flat;
  logic [7:0]    sbox_mem [256];

  always_comb begin
    sbox_data = {sbox_mem[sbox_addr[31:24]], sbox_mem[sbox_addr[23:16]],
                 sbox_mem[sbox_addr[15:8]],  sbox_mem[sbox_addr[7:0]]};
  end

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_mem[x[31:24]], sbox_mem[x[23:16]], sbox_mem[x[15:8]], sbox_mem[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Reference key schedule and index-counter model.
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  int ref_nk    = 4;
  int ref_total = 44;
  int exp_idx   = 0;
  int done_cnt  = 0;

  task automatic build_expected(input logic [255:0] key, input int nk);
    logic [255:0] sh;
    logic [31:0]  t;
    for (int k = 0; k < 64; k++) begin
      exp_w[k] = 32'h0;
      got_w[k] = 32'h0;
    end
    for (int k = 0; k < nk; k++) begin
      sh = key << (32 * k);
      exp_w[k] = sh[255:224];
    end
    for (int k = nk; k < 4 * (nk + 7); k++) begin
      t = exp_w[k-1];
      if (k % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(k / nk), 24'h000000};
      else if (nk == 8 && k % nk == 4) t = sub_word(t);
      exp_w[k] = exp_w[k-nk] ^ t;
    end
  endtask

  always_comb begin
    nw   = ((int'(cnt_i) % ref_nk) == 0) && (int'(cnt_i) >= ref_nk);
    mod4 = (ref_nk == 8) && ((int'(cnt_i) % 8) == 4) && (int'(cnt_i) >= 12);
    fst  = (int'(cnt_i) == ref_nk - 1);
    last = (int'(cnt_i) == ref_total - 1);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cnt_i <= 6'd0;
    else if (cnt_en) cnt_i <= last ? 6'd0 : cnt_i + 6'd1;
  end

  // Stream monitor: stall stability, scoreboard, done pulse.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_w;
    logic [5:0]  prev_i;
    prev_stall = 1'b0;
    prev_w = 32'h0;
    prev_i = 6'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          check_eq("stall_word", word, prev_w);
          check_eq("stall_idx", idx, prev_i);
        end
        if (valid && !ready) begin
          check_eq("stall_cnt_en", cnt_en, 1'b0);
          prev_stall = 1'b1;
          prev_w = word;
          prev_i = idx;
        end else begin
          prev_stall = 1'b0;
        end
        if (valid && ready && exp_idx < 64) begin
          check_eq($sformatf("word%0d", exp_idx), word, exp_w[exp_idx]);
          check_eq($sformatf("idx%0d", exp_idx), idx, exp_idx);
          got_w[idx] = word;
          exp_idx++;
        end
        if (done) begin
          check_eq("done_valid", valid, 1'b1);
          check_eq("done_idx", idx, ref_total - 1);
          done_cnt++;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_word"}, word, 32'h0);
    check_eq({tag, "_idx"}, idx, 6'd0);
    check_eq({tag, "_valid"}, valid, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_cnt_en"}, cnt_en, 1'b0);
    check_eq({tag, "_sbox"}, sbox_addr, 32'h0);
  endtask

  // One expansion run; restart_at pulses a stray start, abort_at resets mid-run.
  task automatic run_case(input logic [1:0] conf, input logic [255:0] key, input int nk,
                          input bit rand_ready, input int restart_at, input int abort_at);
    int cyc;
    bit seen_done;
    bit restarted;
    int done_before;
    build_expected(key, nk);
    ref_nk = nk;
    ref_total = 4 * (nk + 7);
    exp_idx = 0;
    done_before = done_cnt;
    @(posedge clk); #1;
    conf_in = conf; key_in = key; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0; conf_in = ~conf; key_in = ~key;
    cyc = 0; seen_done = 1'b0; restarted = 1'b0;
    while (!seen_done && cyc < 4000) begin
      ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      if (restart_at >= 0 && int'(cnt_i) == restart_at && !restarted) begin
        start_in = 1'b1;
        restarted = 1'b1;
      end else begin
        start_in = 1'b0;
      end
      if (abort_at >= 0 && int'(cnt_i) == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("abort_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        check_eq("abort_no_done", done_cnt - done_before, 0);
        return;
      end
      @(negedge clk);
      if (done) seen_done = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq("done_seen", seen_done, 1'b1);
    if (!rand_ready) check_eq("latency", cyc, ref_total);
    start_in = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    @(negedge clk);
    check_eq("done_one_pulse", done, 1'b0);
    check_eq("idle_after_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("words_taken", exp_idx, ref_total);
    check_eq("done_count", done_cnt - done_before, 1);
  endtask

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic spot128(input string tag);
    check_eq({tag, "_w4"}, got_w[4], 32'ha0fafe17);
    check_eq({tag, "_w43"}, got_w[43], 32'hb6630ca6);
  endtask

  initial begin
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int k = 0; k < 256; k++) sbox_mem[k] = sbox_flat[2047 - 8 * k -: 8];
    rst = 1'b1; start_in = 1'b0; conf_in = 2'b00; key_in = '0; ready = 1'b1;
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // AES-128, back-to-back.
    run_case(2'b00, KEY128, 4, 1'b0, -1, -1);
    spot128("c1");
    // AES-192.
    run_case(2'b01, KEY192, 6, 1'b0, -1, -1);
    check_eq("c2_w6", got_w[6], 32'hfe0c91f7);
    check_eq("c2_w51", got_w[51], 32'h01002202);
    // AES-256, including the SubWord-only word.
    run_case(2'b10, KEY256, 8, 1'b0, -1, -1);
    check_eq("c3_w8", got_w[8], 32'h9ba35411);
    check_eq("c3_w12", got_w[12], 32'ha8b09c1a);
    check_eq("c3_w59", got_w[59], 32'h706c631e);
    // AES-128 with random backpressure.
    run_case(2'b00, KEY128, 4, 1'b1, -1, -1);
    spot128("c4");
    // Reset in the middle of an AES-256 run, then a clean AES-128 run.
    run_case(2'b11, KEY256, 8, 1'b0, -1, 20);
    run_case(2'b00, KEY128, 4, 1'b0, -1, -1);
    spot128("c5");
    // Stray start while busy must be ignored.
    run_case(2'b00, KEY128, 4, 1'b0, 10, -1);
    spot128("c6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
